// File: rtl/cikis_paketleyici_pkg.sv
// Shared constants and types for the output packer: default geometry,
// push classification and the word-count width helper.
package cikis_paketleyici_pkg;

  localparam int PIXEL_BIT_DFLT = 8;
  localparam int PPW_DFLT       = 4;
  localparam int DERINLIK_DFLT  = 8;
  localparam int ESIK_DFLT      = 2;

  typedef enum logic [1:0] {
    PUSH_YOK   = 2'd0,
    PUSH_TAM   = 2'd1,
    PUSH_KISMI = 2'd2
  } push_tur_e;

  // Width of the valid-pixel count: must hold 0..PPW inclusive.
  function automatic int say_bit(input int ppw);
    return $clog2(ppw) + 1;
  endfunction

endpackage

// File: rtl/cikis_paketleyici_if.sv
// Packed-word output port toward the memory/bus writer (valid/ready).
interface cikis_paketleyici_if #(
  parameter int WORD_BIT = 32,
  parameter int SAY_BIT  = 3
);
  logic                veri_gecerli;
  logic [WORD_BIT-1:0] veri;
  logic [SAY_BIT-1:0]  veri_say;
  logic                veri_son;
  logic                veri_hazir;

  modport master (output veri_gecerli, veri, veri_say, veri_son, input veri_hazir);
  modport slave  (input veri_gecerli, veri, veri_say, veri_son, output veri_hazir);
endinterface

// File: rtl/cikis_paketleyici_senkron_fifo.sv
// Generic show-ahead synchronous FIFO; a push while full is accepted only
// when a pop happens in the same cycle.
module senkron_fifo #(
  parameter int GENISLIK = 36,
  parameter int DERIN    = 8,
  localparam int AW      = $clog2(DERIN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [GENISLIK-1:0] veri_i,
  input  logic                pop_i,
  output logic [GENISLIK-1:0] veri_o,
  output logic                dolu_o,
  output logic                bos_o,
  output logic [AW:0]         doluluk_o
);

  logic [GENISLIK-1:0] mem [DERIN];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         doluluk_q;
  logic                yaz, oku;

  assign dolu_o    = (doluluk_q == (AW+1)'(DERIN));
  assign bos_o     = (doluluk_q == '0);
  assign doluluk_o = doluluk_q;
  assign yaz       = push_i && (!dolu_o || pop_i);
  assign oku       = pop_i && !bos_o;
  assign veri_o    = mem[rd_q];

  always_ff @(posedge clk_i) begin
    if (yaz) mem[wr_q] <= veri_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q      <= '0;
      rd_q      <= '0;
      doluluk_q <= '0;
    end else begin
      if (yaz) wr_q <= wr_q + 1'b1;
      if (oku) rd_q <= rd_q + 1'b1;
      if (yaz && !oku)      doluluk_q <= doluluk_q + 1'b1;
      else if (!yaz && oku) doluluk_q <= doluluk_q - 1'b1;
    end
  end

endmodule

// File: rtl/cikis_paketleyici.sv
// Output stage after the task unit: packs PPW pixels per word, queues the
// words, flushes partial words at frame end and back-pressures the source.
//
// state (idx_q) | meaning
// 0             | no pixels held in the pack register
// 1..PPW-1      | that many pixels held, waiting for the rest
module cikis_paketleyici
  import cikis_paketleyici_pkg::*;
#(
  parameter int PIXEL_BIT = PIXEL_BIT_DFLT,
  parameter int PPW       = PPW_DFLT,
  parameter int DERINLIK  = DERINLIK_DFLT,
  parameter int ESIK      = ESIK_DFLT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  etkin_i,
  input  logic [PIXEL_BIT-1:0]  pixel_i,
  input  logic                  resim_bitti_i,
  output logic                  stal_o,
  output logic                  tasma_o,
  cikis_paketleyici_if.master   cikis
);

  localparam int WORD_BIT = PIXEL_BIT * PPW;
  localparam int SAY_BIT  = say_bit(PPW);
  localparam int IDX_BIT  = $clog2(PPW);
  localparam int GENISLIK = WORD_BIT + SAY_BIT + 1;
  localparam int FAW      = $clog2(DERINLIK);

  logic [IDX_BIT-1:0]               idx_q, idx_d;
  logic [PPW-1:0][PIXEL_BIT-1:0]    paket_q, paket_d, kelime_d;
  logic [SAY_BIT-1:0]               push_say;
  logic                             push_son;
  push_tur_e                        tur;

  logic                push, pop, dolu, bos;
  logic [GENISLIK-1:0] fifo_bas;
  logic [FAW:0]        doluluk, doluluk_sonraki;
  logic                stal_q, tasma_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      paket_q <= '0;
    end else begin
      idx_q   <= idx_d;
      paket_q <= paket_d;
    end
  end

  // A completing pixel takes priority over flush so that resim_bitti_i on
  // the last slot yields one full word marked son, not an extra marker.
  always_comb begin
    tur      = PUSH_YOK;
    idx_d    = idx_q;
    paket_d  = paket_q;
    kelime_d = paket_q;
    push_say = '0;
    push_son = 1'b0;
    if (etkin_i) kelime_d[idx_q] = pixel_i;

    if (etkin_i && idx_q == IDX_BIT'(PPW-1)) tur = PUSH_TAM;
    else if (resim_bitti_i)                  tur = PUSH_KISMI;

    case (tur)
      PUSH_TAM: begin
        push_say = SAY_BIT'(PPW);
        push_son = resim_bitti_i;
        idx_d    = '0;
        paket_d  = '0;
      end
      PUSH_KISMI: begin
        push_say = SAY_BIT'(idx_q) + SAY_BIT'(etkin_i);
        push_son = 1'b1;
        idx_d    = '0;
        paket_d  = '0;
      end
      default: begin
        if (etkin_i) begin
          idx_d   = idx_q + 1'b1;
          paket_d = kelime_d;
        end
      end
    endcase
  end

  assign push = (tur != PUSH_YOK);
  assign pop  = !bos && cikis.veri_hazir;

  senkron_fifo #(
    .GENISLIK (GENISLIK),
    .DERIN    (DERINLIK)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .veri_i    ({kelime_d, push_say, push_son}),
    .pop_i     (pop),
    .veri_o    (fifo_bas),
    .dolu_o    (dolu),
    .bos_o     (bos),
    .doluluk_o (doluluk)
  );

  // Mirrors the FIFO's own accept rule so stall tracks the fill after this edge.
  assign doluluk_sonraki = doluluk + (FAW+1)'(push && (!dolu || pop)) - (FAW+1)'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stal_q  <= 1'b0;
      tasma_q <= 1'b0;
    end else begin
      stal_q <= (doluluk_sonraki >= (FAW+1)'(DERINLIK - ESIK));
      if (push && dolu && !pop) tasma_q <= 1'b1;
    end
  end

  assign stal_o             = stal_q;
  assign tasma_o            = tasma_q;
  assign cikis.veri_gecerli = !bos;
  assign {cikis.veri, cikis.veri_say, cikis.veri_son} = bos ? '0 : fifo_bas;

endmodule

// File: tb/tb_cikis_paketleyici.sv
// Scoreboard bench for cikis_paketleyici: a behavioural packer/queue model
// pushes expected words as pixels are driven and pops them on each DUT pop.
module tb_cikis_paketleyici;
  import cikis_paketleyici_pkg::*;

  localparam int PIXEL_BIT = PIXEL_BIT_DFLT;
  localparam int PPW       = PPW_DFLT;
  localparam int DERINLIK  = DERINLIK_DFLT;
  localparam int ESIK      = ESIK_DFLT;
  localparam int WORD_BIT  = PIXEL_BIT * PPW;
  localparam int SAY_BIT   = say_bit(PPW);

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 etkin_i = 1'b0;
  logic [PIXEL_BIT-1:0] pixel_i = '0;
  logic                 resim_bitti_i = 1'b0;
  logic                 stal_o, tasma_o;

  cikis_paketleyici_if #(.WORD_BIT(WORD_BIT), .SAY_BIT(SAY_BIT)) cikis ();

  cikis_paketleyici #(
    .PIXEL_BIT (PIXEL_BIT),
    .PPW       (PPW),
    .DERINLIK  (DERINLIK),
    .ESIK      (ESIK)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .etkin_i       (etkin_i),
    .pixel_i       (pixel_i),
    .resim_bitti_i (resim_bitti_i),
    .stal_o        (stal_o),
    .tasma_o       (tasma_o),
    .cikis         (cikis)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [WORD_BIT-1:0] veri;
    logic [SAY_BIT-1:0]  say;
    logic                son;
  } kayit_t;

  kayit_t              beklenen_q[$];
  int                  m_idx = 0;
  logic [WORD_BIT-1:0] m_paket = '0;
  logic                m_tasma = 1'b0;
  int                  kontrol_sayisi = 0;
  int                  hata_sayisi = 0;

  task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%0h beklenen=%0h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  task automatic model_it(input logic [WORD_BIT-1:0] veri, input int say, input logic son);
    kayit_t k;
    k.veri = veri;
    k.say  = SAY_BIT'(say);
    k.son  = son;
    if (beklenen_q.size() < DERINLIK) beklenen_q.push_back(k);
    else m_tasma = 1'b1;
  endtask

  // One clock cycle: drive at negedge, check state left by the previous edge,
  // score any pop, then advance the packing model for this edge.
  task automatic adim(input logic etkin, input logic [PIXEL_BIT-1:0] pix, input logic bitti, input logic hazir);
    kayit_t k;
    @(negedge clk_i);
    etkin_i          = etkin;
    pixel_i          = pix;
    resim_bitti_i    = bitti;
    cikis.veri_hazir = hazir;
    #1;
    kontrol("gecerli", 64'(cikis.veri_gecerli), 64'(beklenen_q.size() != 0));
    kontrol("stal", 64'(stal_o), 64'(beklenen_q.size() >= DERINLIK - ESIK));
    kontrol("tasma", 64'(tasma_o), 64'(m_tasma));
    if (beklenen_q.size() != 0 && hazir) begin
      k = beklenen_q.pop_front();
      kontrol("veri", 64'(cikis.veri), 64'(k.veri));
      kontrol("say", 64'(cikis.veri_say), 64'(k.say));
      kontrol("son", 64'(cikis.veri_son), 64'(k.son));
    end
    if (etkin) m_paket[m_idx*PIXEL_BIT +: PIXEL_BIT] = pix;
    if (etkin && m_idx == PPW-1) begin
      model_it(m_paket, PPW, bitti);
      m_idx = 0; m_paket = '0;
    end else if (bitti) begin
      model_it(m_paket, etkin ? m_idx + 1 : m_idx, 1'b1);
      m_idx = 0; m_paket = '0;
    end else if (etkin) begin
      m_idx++;
    end
    @(posedge clk_i);
  endtask

  task automatic sifirla();
    @(negedge clk_i);
    rst_i = 1'b1; etkin_i = 1'b0; pixel_i = '0; resim_bitti_i = 1'b0;
    cikis.veri_hazir = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    beklenen_q.delete();
    m_idx = 0; m_paket = '0; m_tasma = 1'b0;
    kontrol("rst_stal", 64'(stal_o), 64'(0));
    kontrol("rst_gecerli", 64'(cikis.veri_gecerli), 64'(0));
    kontrol("rst_veri", 64'(cikis.veri), 64'(0));
    kontrol("rst_say", 64'(cikis.veri_say), 64'(0));
    kontrol("rst_son", 64'(cikis.veri_son), 64'(0));
    kontrol("rst_tasma", 64'(tasma_o), 64'(0));
  endtask

  task automatic bosalt();
    for (int n = 0; n < 3*DERINLIK && beklenen_q.size() != 0; n++) adim(1'b0, '0, 1'b0, 1'b1);
    adim(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    cikis.veri_hazir = 1'b0;
    sifirla();

    // 1: two full words
    for (int i = 1; i <= 8; i++) adim(1'b1, PIXEL_BIT'(i), 1'b0, 1'b1);
    bosalt();

    // 2: one full word then a one-pixel flush
    for (int i = 'h11; i <= 'h15; i++) adim(1'b1, PIXEL_BIT'(i), 1'b0, 1'b1);
    adim(1'b0, '0, 1'b1, 1'b1);
    bosalt();

    // 3: frame end coincides with the completing pixel
    for (int i = 'h31; i <= 'h34; i++) adim(1'b1, PIXEL_BIT'(i), i == 'h34, 1'b1);
    bosalt();

    // 4: frame end with nothing held -> marker word
    adim(1'b0, '0, 1'b1, 1'b1);
    bosalt();

    // 5: no drain, 9 words -> stall at 6, 9th dropped, then drain
    for (int i = 0; i < 9*PPW; i++) adim(1'b1, PIXEL_BIT'('h40 + i), 1'b0, 1'b0);
    bosalt();

    // 6: full FIFO with simultaneous push and pop, then reset mid-frame
    sifirla();
    for (int i = 0; i < 8*PPW; i++) adim(1'b1, PIXEL_BIT'('h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < PPW; i++) adim(1'b1, PIXEL_BIT'('hC0 + i), 1'b0, i == PPW-1);
    for (int i = 0; i < 3; i++) adim(1'b0, '0, 1'b0, 1'b0);
    adim(1'b1, 8'hE1, 1'b0, 1'b0);
    adim(1'b1, 8'hE2, 1'b0, 1'b0);
    sifirla();
    for (int i = 0; i < PPW; i++) adim(1'b1, PIXEL_BIT'('hF0 + i), 1'b0, 1'b1);
    bosalt();

    $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL zaman_asimi: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
